// File: rtl/fetch_queue.sv
// Two-slot instruction fetch queue between instruction memory and decode.
// Tracks in-flight requests per slot and discards responses that a redirect made stale.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_FULL    = 2'd2
    } slot_t;

    slot_t       slot_state [2];
    logic [31:0] slot_addr  [2];
    logic [31:0] slot_data  [2];
    logic [31:0] pc;
    logic        alloc_ptr;
    logic        fill_ptr;
    logic        head_ptr;
    logic [1:0]  drop_cnt;

    logic        req_fire;
    logic        resp_drop;
    logic        resp_fill;
    logic        deq;
    logic [2:0]  pending_cnt;
    logic [2:0]  outstanding;
    logic [2:0]  drop_next;
    logic [1:0]  drop_sat;

    assign imem_req_valid = !reset && !redirect && (slot_state[alloc_ptr] == SLOT_EMPTY);
    assign imem_req_addr  = pc;

    assign id_valid       = (slot_state[head_ptr] == SLOT_FULL);
    assign id_instruction = slot_data[head_ptr];
    assign id_pc          = slot_addr[head_ptr];

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign resp_drop = imem_resp_valid && (drop_cnt != 2'd0);
    assign resp_fill = imem_resp_valid && (drop_cnt == 2'd0) &&
                       (slot_state[fill_ptr] == SLOT_PENDING);
    assign deq       = id_valid && id_ready;

    // On redirect every request still owed by memory becomes stale; a response
    // arriving in the redirect cycle is one of them and is consumed right away.
    always_comb begin
        pending_cnt = {2'b00, slot_state[0] == SLOT_PENDING} +
                      {2'b00, slot_state[1] == SLOT_PENDING};
        outstanding = {1'b0, drop_cnt} + pending_cnt;
        drop_next   = outstanding;
        if (imem_resp_valid && (outstanding != 3'd0)) begin
            drop_next = outstanding - 3'd1;
        end
        drop_sat = (drop_next > 3'd3) ? 2'd3 : drop_next[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                slot_state[i] <= SLOT_EMPTY;
                slot_addr[i]  <= 32'h0;
                slot_data[i]  <= 32'h0;
            end
            pc        <= RESET_PC;
            alloc_ptr <= 1'b0;
            fill_ptr  <= 1'b0;
            head_ptr  <= 1'b0;
            drop_cnt  <= 2'd0;
        end else if (redirect) begin
            for (int i = 0; i < 2; i++) begin
                slot_state[i] <= SLOT_EMPTY;
            end
            pc        <= {redirect_target[31:2], 2'b00};
            alloc_ptr <= 1'b0;
            fill_ptr  <= 1'b0;
            head_ptr  <= 1'b0;
            drop_cnt  <= drop_sat;
        end else begin
            // Allocate, fill and dequeue always touch slots in distinct states,
            // so all three can land in the same cycle without conflict.
            if (req_fire) begin
                slot_state[alloc_ptr] <= SLOT_PENDING;
                slot_addr[alloc_ptr]  <= pc;
                alloc_ptr             <= ~alloc_ptr;
                pc                    <= pc + 32'd4;
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - 2'd1;
            end
            if (resp_fill) begin
                slot_state[fill_ptr] <= SLOT_FULL;
                slot_data[fill_ptr]  <= imem_resp_data;
                fill_ptr             <= ~fill_ptr;
            end
            if (deq) begin
                slot_state[head_ptr] <= SLOT_EMPTY;
                head_ptr             <= ~head_ptr;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector tables for the corner cases, then random
// traffic checked against a generation-tagged queue model of the fetch stream.
module tb_fetch_queue;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic        id_ready = 1'b0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_ready       (id_ready)
    );

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        idr;
        logic        redir;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_id;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        full;
        logic [31:0] data;
    } fent_t;

    typedef struct {
        logic [31:0] addr;
        int          gen;
        logic [31:0] data;
    } ment_t;

    function automatic logic [31:0] f(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rdata,
                                input logic idr, input logic redir, input logic [31:0] tgt,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_id, input logic [31:0] e_pc,
                                input logic [31:0] e_instr);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.idr = idr; v.redir = redir; v.tgt = tgt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_id = e_id; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic idle_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        id_ready        = 1'b0;
    endtask

    // Entered and left at a falling edge.
    task automatic apply_vec(input vec_t v, input string tag);
        imem_req_ready  = v.rdy;
        imem_resp_valid = v.rv;
        imem_resp_data  = v.rdata;
        id_ready        = v.idr;
        redirect        = v.redir;
        redirect_target = v.tgt;
        #1;
        check($sformatf("%s.req_valid", tag), {31'h0, imem_req_valid}, {31'h0, v.e_req});
        if (v.e_req) check($sformatf("%s.req_addr", tag), imem_req_addr, v.e_addr);
        check($sformatf("%s.id_valid", tag), {31'h0, id_valid}, {31'h0, v.e_id});
        if (v.e_id) begin
            check($sformatf("%s.id_pc", tag), id_pc, v.e_pc);
            check($sformatf("%s.id_instr", tag), id_instruction, v.e_instr);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        imem_req_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("%s.rst_req_valid", tag), {31'h0, imem_req_valid}, 32'h0);
        check($sformatf("%s.rst_id_valid", tag), {31'h0, id_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    vec_t  tbl [6];
    fent_t fq[$];
    ment_t mq[$];

    initial begin
        // Streaming fetch with 1-cycle memory latency and an always-ready decoder.
        tbl[0] = mk(H, L, 32'h0, H, L, 32'h0, H, 32'h0,  L, 32'h0, 32'h0);
        tbl[1] = mk(H, H, f(32'h0), H, L, 32'h0, H, 32'h4,  L, 32'h0, 32'h0);
        tbl[2] = mk(H, H, f(32'h4), H, L, 32'h0, L, 32'h0,  H, 32'h0, f(32'h0));
        tbl[3] = mk(H, L, 32'h0, H, L, 32'h0, H, 32'h8,  H, 32'h4, f(32'h4));
        tbl[4] = mk(L, H, f(32'h8), H, L, 32'h0, H, 32'hC,  L, 32'h0, 32'h0);
        tbl[5] = mk(L, L, 32'h0, H, L, 32'h0, H, 32'hC,  H, 32'h8, f(32'h8));

        do_reset("stream");
        for (int i = 0; i < 6; i++) apply_vec(tbl[i], $sformatf("stream%0d", i));

        // Decoder stalled: only two requests go out, order preserved on release.
        do_reset("stall");
        apply_vec(mk(H, L, 32'h0,    L, L, 32'h0, H, 32'h0, L, 32'h0, 32'h0), "stall0");
        apply_vec(mk(H, H, f(32'h0), L, L, 32'h0, H, 32'h4, L, 32'h0, 32'h0), "stall1");
        apply_vec(mk(H, H, f(32'h4), L, L, 32'h0, L, 32'h0, H, 32'h0, f(32'h0)), "stall2");
        apply_vec(mk(H, L, 32'h0,    L, L, 32'h0, L, 32'h0, H, 32'h0, f(32'h0)), "stall3");
        apply_vec(mk(H, L, 32'h0,    L, L, 32'h0, L, 32'h0, H, 32'h0, f(32'h0)), "stall4");
        apply_vec(mk(H, L, 32'h0,    H, L, 32'h0, L, 32'h0, H, 32'h0, f(32'h0)), "stall5");
        apply_vec(mk(L, L, 32'h0,    L, L, 32'h0, H, 32'h8, H, 32'h4, f(32'h4)), "stall6");
        apply_vec(mk(L, L, 32'h0,    H, L, 32'h0, H, 32'h8, H, 32'h4, f(32'h4)), "stall7");
        apply_vec(mk(L, L, 32'h0,    L, L, 32'h0, H, 32'h8, L, 32'h0, 32'h0), "stall8");

        // Redirect with two requests in flight: both stale responses dropped.
        do_reset("redir");
        apply_vec(mk(H, L, 32'h0,      H, L, 32'h0,   H, 32'h0,   L, 32'h0, 32'h0), "redir0");
        apply_vec(mk(H, L, 32'h0,      H, L, 32'h0,   H, 32'h4,   L, 32'h0, 32'h0), "redir1");
        apply_vec(mk(H, L, 32'h0,      H, H, 32'h103, L, 32'h0,   L, 32'h0, 32'h0), "redir2");
        apply_vec(mk(H, H, f(32'h0),   H, L, 32'h0,   H, 32'h100, L, 32'h0, 32'h0), "redir3");
        apply_vec(mk(L, H, f(32'h4),   H, L, 32'h0,   H, 32'h104, L, 32'h0, 32'h0), "redir4");
        apply_vec(mk(L, H, f(32'h100), H, L, 32'h0,   H, 32'h104, L, 32'h0, 32'h0), "redir5");
        apply_vec(mk(L, L, 32'h0,      H, L, 32'h0,   H, 32'h104, H, 32'h100, f(32'h100)), "redir6");
        apply_vec(mk(L, L, 32'h0,      H, L, 32'h0,   H, 32'h104, L, 32'h0, 32'h0), "redir7");

        // Redirect colliding with a response and a decode handshake.
        do_reset("coll");
        apply_vec(mk(H, L, 32'h0,      H, L, 32'h0,   H, 32'h0,   L, 32'h0, 32'h0), "coll0");
        apply_vec(mk(H, H, f(32'h0),   H, L, 32'h0,   H, 32'h4,   L, 32'h0, 32'h0), "coll1");
        apply_vec(mk(H, H, f(32'h4),   H, H, 32'h200, L, 32'h0,   H, 32'h0, f(32'h0)), "coll2");
        apply_vec(mk(H, L, 32'h0,      H, L, 32'h0,   H, 32'h200, L, 32'h0, 32'h0), "coll3");
        apply_vec(mk(L, H, f(32'h200), H, L, 32'h0,   H, 32'h204, L, 32'h0, 32'h0), "coll4");
        apply_vec(mk(L, L, 32'h0,      H, L, 32'h0,   H, 32'h204, H, 32'h200, f(32'h200)), "coll5");

        // PC wrap at the top of the address space, with an unaligned target.
        do_reset("wrap");
        apply_vec(mk(L, L, 32'h0, L, H, 32'hFFFF_FFFE, L, 32'h0, L, 32'h0, 32'h0), "wrap0");
        apply_vec(mk(H, L, 32'h0, L, L, 32'h0, H, 32'hFFFF_FFFC, L, 32'h0, 32'h0), "wrap1");
        apply_vec(mk(L, H, f(32'hFFFF_FFFC), L, L, 32'h0, H, 32'h0, L, 32'h0, 32'h0), "wrap2");
        apply_vec(mk(L, L, 32'h0, H, L, 32'h0, H, 32'h0, H, 32'hFFFF_FFFC, f(32'hFFFF_FFFC)), "wrap3");

        // A response with nothing in flight must be ignored.
        do_reset("illegal");
        $display("note: injecting illegal response with no request outstanding");
        apply_vec(mk(L, H, 32'hDEAD_BEEF, L, L, 32'h0, H, 32'h0, L, 32'h0, 32'h0), "illegal0");
        apply_vec(mk(L, L, 32'h0,         L, L, 32'h0, H, 32'h0, L, 32'h0, 32'h0), "illegal1");

        // Asynchronous reset between edges with both slots full.
        do_reset("async");
        apply_vec(mk(H, L, 32'h0,    L, L, 32'h0, H, 32'h0, L, 32'h0, 32'h0), "async0");
        apply_vec(mk(H, H, f(32'h0), L, L, 32'h0, H, 32'h4, L, 32'h0, 32'h0), "async1");
        apply_vec(mk(L, H, f(32'h4), L, L, 32'h0, L, 32'h0, H, 32'h0, f(32'h0)), "async2");
        idle_inputs();
        imem_req_ready = 1'b1;
        #3 reset = 1'b1;
        #1;
        check("async.id_valid", {31'h0, id_valid}, 32'h0);
        check("async.req_valid", {31'h0, imem_req_valid}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        apply_vec(mk(H, L, 32'h0, L, L, 32'h0, H, 32'h0, L, 32'h0, 32'h0), "async3");
        apply_vec(mk(L, L, 32'h0, L, L, 32'h0, H, 32'h4, L, 32'h0, 32'h0), "async4");

        // Random traffic against the queue model.
        begin
            int          gen;
            logic [31:0] mpc;
            do_reset("rnd");
            gen = 0;
            mpc = 32'h0;
            fq.delete();
            mq.delete();
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic        rdy, rv, idr, rd, e_req, e_id, found;
                logic [31:0] tgt;
                ment_t       m;
                fent_t       e;
                rd  = ($urandom_range(0, 24) == 0);
                tgt = $urandom;
                rv  = (mq.size() > 0) && ($urandom_range(0, 9) < 6);
                rdy = (mq.size() < 2) && ($urandom_range(0, 3) != 0);
                idr = ($urandom_range(0, 3) != 0);
                imem_req_ready  = rdy;
                imem_resp_valid = rv;
                imem_resp_data  = rv ? mq[0].data : $urandom;
                id_ready        = idr;
                redirect        = rd;
                redirect_target = tgt;
                #1;
                e_req = (fq.size() < 2) && !rd;
                e_id  = (fq.size() > 0) && fq[0].full;
                check("rnd.req_valid", {31'h0, imem_req_valid}, {31'h0, e_req});
                if (e_req) check("rnd.req_addr", imem_req_addr, mpc);
                check("rnd.id_valid", {31'h0, id_valid}, {31'h0, e_id});
                if (e_id) begin
                    check("rnd.id_pc", id_pc, fq[0].addr);
                    check("rnd.id_instr", id_instruction, fq[0].data);
                end
                m = '{addr: 32'h0, gen: -1, data: 32'h0};
                if (rv) m = mq.pop_front();
                if (rd) begin
                    gen++;
                    fq.delete();
                    mpc = {tgt[31:2], 2'b00};
                end else begin
                    if (rv && (m.gen == gen)) begin
                        found = 1'b0;
                        for (int i = 0; i < fq.size(); i++) begin
                            if (!found && !fq[i].full) begin
                                e = fq[i];
                                e.full = 1'b1;
                                e.data = m.data;
                                fq[i] = e;
                                found = 1'b1;
                            end
                        end
                        if (!found) $display("FAIL rnd.illegal_resp: response at 0x%08h with no fetch awaiting it", m.addr);
                    end
                    if (e_req && rdy) begin
                        fq.push_back('{addr: mpc, full: 1'b0, data: 32'h0});
                        mq.push_back('{addr: mpc, gen: gen, data: $urandom});
                        mpc = mpc + 32'd4;
                    end
                    if (e_id && idr) void'(fq.pop_front());
                end
                @(posedge clk);
                @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
